mux4_scan_ctrl: RTL and testbench

Round-robin scan controller that sits around the 4:1 bit multiplexer: it drives the multiplexer's `s0`/`s1` select lines through all four channels and captures the selected output `y` into a 4-bit word. It turns four independent single-bit sources into one registered parallel word with a valid/ready handshake. It supports single-shot and continuous scanning, with a programmable settle (dwell) time per channel.

---
 rtl/mux4_scan_ctrl_pkg.sv | 26 ++
 rtl/mux4_scan_ctrl_if.sv | 27 ++
 rtl/scan_dwell_cnt.sv | 47 ++++
 rtl/mux4_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_mux4_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux4_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mux4_scan_pkg
// Shared definitions for the 4:1 multiplexer scan controller:
//   - FSM state encoding (IDLE / SCAN / HOLD)
//   - channel index constants (a..d -> 0..3)
//   - mapping from a channel index to the multiplexer {s0, s1} selects
// -----------------------------------------------------------------------------
package mux4_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    // Returns {s0, s1}. s0 picks the pair (index MSB), s1 picks within the pair.
    function automatic logic [1:0] ch_to_sel(input logic [1:0] ch);
        return {ch[1], ch[0]};
    endfunction

endpackage

// File: rtl/mux4_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux4_scan_ctrl_if
// Output-word handshake between the scan controller and its consumer.
//   data_out : captured 4-bit word, bit k = channel k
//   valid    : data_out complete and stable
//   ready    : consumer accepts data_out
// master = scan controller (producer), slave = consumer.
// -----------------------------------------------------------------------------
interface mux4_scan_ctrl_if;

    logic [3:0] data_out;
    logic       valid;
    logic       ready;

    modport master (
        output data_out,
        output valid,
        input  ready
    );

    modport slave (
        input  data_out,
        input  valid,
        output ready
    );

endinterface

// File: rtl/scan_dwell_cnt.sv
// -----------------------------------------------------------------------------
// scan_dwell_cnt
// Per-channel dwell counter. Counts 0..DWELL-1 while enabled and wraps to 0
// on the cycle 'done' is high, so a new dwell window starts immediately.
// Ports:
//   clk   : clock (rising edge)
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear (priority over en)
//   en    : count enable
//   done  : high while the count equals DWELL-1 (last cycle of the window)
// -----------------------------------------------------------------------------
module scan_dwell_cnt #(
    parameter int unsigned DWELL = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = done ? '0 : (cnt_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux4_scan_ctrl
// Round-robin scan controller around a 4:1 bit multiplexer. Steps the select
// lines through channels 0..3, holds each for DWELL cycles, samples y on the
// last cycle of each window into data_out[ch], then presents the word with a
// valid/ready handshake. Single-shot (cont=0) or continuous (cont=1) scanning.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   start      : begin a scan (only looked at in IDLE)
//   cont       : continuous mode, looked at when a word is accepted
//   y          : multiplexer output
//   s0, s1     : multiplexer selects, {s0,s1} = channel index
//   busy       : high in SCAN or HOLD
//   bus        : data_out / valid / ready handshake (master side)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mux4_scan_ctrl
    import mux4_scan_pkg::*;
#(
    parameter int unsigned DWELL = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cont,
    input  logic                   y,
    output logic                   s0,
    output logic                   s1,
    output logic                   busy,
    mux4_scan_ctrl_if.master       bus
);

    if (DWELL == 0 || DWELL >= (64'd1 << CNT_W)) begin : g_bad_dwell
        $fatal(1, "mux4_scan_ctrl: DWELL must be in 1..2**CNT_W-1");
    end

    state_e     state_q, state_d;
    logic [1:0] ch_q,    ch_d;
    logic [3:0] data_q,  data_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic [1:0] sel_q,   sel_d;

    logic dwell_done;
    logic cnt_en;
    logic cnt_clr;

    // The counter only runs in SCAN; it is held at zero everywhere else so a
    // scan entered from IDLE or HOLD always starts a fresh window.
    assign cnt_en  = (state_q == ST_SCAN);
    assign cnt_clr = !cnt_en;

    scan_dwell_cnt #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .done  (dwell_done)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        data_d  = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    ch_d    = CH_A;
                end
            end
            ST_SCAN: begin
                if (dwell_done) begin
                    data_d[ch_q] = y;
                    if (ch_q == CH_D) begin
                        state_d = ST_HOLD;
                        ch_d    = CH_A;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (valid_q && bus.ready) begin
                    state_d = cont ? ST_SCAN : ST_IDLE;
                    ch_d    = CH_A;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = CH_A;
            end
        endcase

        // Outputs are derived from the next state so they can be registered
        // without adding a cycle of latency.
        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d != ST_IDLE);
        sel_d   = (state_d == ST_SCAN) ? ch_to_sel(ch_d) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= CH_A;
            data_q  <= 4'b0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
        end
    end

    assign s0           = sel_q[1];
    assign s1           = sel_q[0];
    assign busy         = busy_q;
    assign bus.data_out = data_q;
    assign bus.valid    = valid_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux4_scan_ctrl
// Two controllers (DWELL=1 and DWELL=3) share control inputs and the four
// source bits, each with its own 4:1 mux. A timeline reference model checks
// every output of both instances every cycle; directed sequences add explicit
// checks for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_mux4_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       cont;
    logic       ready;
    logic [3:0] src;          // bit k = channel k input (a = bit 0 .. d = bit 3)

    logic s0_1, s1_1, busy_1, y_1;
    logic s0_3, s1_3, busy_3, y_3;

    mux4_scan_ctrl_if bus1();
    mux4_scan_ctrl_if bus3();

    assign bus1.ready = ready;
    assign bus3.ready = ready;

    // The 4:1 multiplexers being scanned.
    assign y_1 = s0_1 ? (s1_1 ? src[3] : src[2]) : (s1_1 ? src[1] : src[0]);
    assign y_3 = s0_3 ? (s1_3 ? src[3] : src[2]) : (s1_3 ? src[1] : src[0]);

    mux4_scan_ctrl #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cont  (cont),
        .y     (y_1),
        .s0    (s0_1),
        .s1    (s1_1),
        .busy  (busy_1),
        .bus   (bus1)
    );

    mux4_scan_ctrl #(.DWELL(3), .CNT_W(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cont  (cont),
        .y     (y_3),
        .s0    (s0_3),
        .s1    (s1_3),
        .busy  (busy_3),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: mode 0 idle, 1 scanning, 2 word presented.
    // During a scan, el = cycles elapsed since the first selected cycle;
    // the selected channel is el/D and the sample happens on el%D == D-1.
    int         d_of   [2] = '{1, 3};
    int         m_mode [2];
    int         m_el   [2];
    logic [3:0] m_word [2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_edge(input int i, input logic rn, input logic st, input logic ct,
                              input logic rd, input logic [3:0] ab);
        int k;
        if (!rn) begin
            m_mode[i] = 0; m_el[i] = 0; m_word[i] = 4'b0000;
        end else if (m_mode[i] == 0) begin
            if (st) begin m_mode[i] = 1; m_el[i] = 0; end
        end else if (m_mode[i] == 1) begin
            k = m_el[i] / d_of[i];
            if (m_el[i] % d_of[i] == d_of[i] - 1) m_word[i][k] = ab[k];
            if (m_el[i] == 4 * d_of[i] - 1) m_mode[i] = 2;
            else m_el[i] = m_el[i] + 1;
        end else begin
            if (rd) begin m_mode[i] = ct ? 1 : 0; m_el[i] = 0; end
        end
    endtask

    // One clock: capture inputs, advance the model, compare all outputs.
    task automatic step();
        logic st, ct, rd, rn;
        logic [3:0] ab;
        st = start; ct = cont; rd = ready; rn = rst_n; ab = src;
        if (rn && rd && bus1.valid) $display("cycle %0d: DWELL=1 word %b accepted", cyc, bus1.data_out);
        if (rn && rd && bus3.valid) $display("cycle %0d: DWELL=3 word %b accepted", cyc, bus3.data_out);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, rn, st, ct, rd, ab);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic [1:0] a_sel, e_sel;
            logic       a_v, a_b;
            logic [3:0] a_d;
            if (i == 0) begin
                a_sel = {s0_1, s1_1}; a_v = bus1.valid; a_b = busy_1; a_d = bus1.data_out;
            end else begin
                a_sel = {s0_3, s1_3}; a_v = bus3.valid; a_b = busy_3; a_d = bus3.data_out;
            end
            e_sel = (m_mode[i] == 1) ? 2'(m_el[i] / d_of[i]) : 2'b00;
            check($sformatf("model_d%0d_sel", d_of[i]),   {6'd0, a_sel}, {6'd0, e_sel});
            check($sformatf("model_d%0d_valid", d_of[i]), {7'd0, a_v},   {7'd0, m_mode[i] == 2});
            check($sformatf("model_d%0d_busy", d_of[i]),  {7'd0, a_b},   {7'd0, m_mode[i] != 0});
            check($sformatf("model_d%0d_data", d_of[i]),  {4'd0, a_d},   {4'd0, m_word[i]});
        end
    endtask

    typedef struct {
        logic       st;
        logic [1:0] sel;
        logic       v;
        logic       b;
        logic [3:0] d;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int w;
        int vcount1, vcount3;
        int vcyc [$];
        logic [3:0] vword [$];

        for (int i = 0; i < 2; i++) begin m_mode[i] = 0; m_el[i] = 0; m_word[i] = 4'b0000; end
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b0; src = 4'b0000;

        // ---- reset state
        step(); step();
        check("reset_valid", {7'd0, bus1.valid}, 8'd0);
        check("reset_busy",  {7'd0, busy_3}, 8'd0);
        check("reset_data",  {4'd0, bus3.data_out}, 8'd0);
        rst_n = 1'b1;

        // ---- DWELL=1 single shot, table driven (row j: inputs of cycle j, outputs of cycle j+1)
        tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b1, 4'b0000};
        tbl[1] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'b0001};
        tbl[2] = '{1'b0, 2'd2, 1'b0, 1'b1, 4'b0001};
        tbl[3] = '{1'b0, 2'd3, 1'b0, 1'b1, 4'b0101};
        tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b1, 4'b1101};
        tbl[5] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'b1101};
        src = 4'b1101; ready = 1'b1; cont = 1'b0;
        for (int j = 0; j < 6; j++) begin
            start = tbl[j].st;
            step();
            check($sformatf("tbl%0d_sel", j),   {6'd0, s0_1, s1_1}, {6'd0, tbl[j].sel});
            check($sformatf("tbl%0d_valid", j), {7'd0, bus1.valid}, {7'd0, tbl[j].v});
            check($sformatf("tbl%0d_busy", j),  {7'd0, busy_1}, {7'd0, tbl[j].b});
            check($sformatf("tbl%0d_data", j),  {4'd0, bus1.data_out}, {4'd0, tbl[j].d});
        end
        start = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;

        // ---- DWELL=3 with c glitching early in its window (cycles 7,8; sampled at 9)
        for (int rc = 0; rc < 14; rc++) begin
            start = (rc == 0);
            src   = 4'b0110;
            if (rc == 7 || rc == 8) src[2] = 1'b0;
            step();
            if (rc + 1 == 7)  check("d3_sel_c", {6'd0, s0_3, s1_3}, 8'd2);
            if (rc + 1 == 12) check("d3_valid_early", {7'd0, bus3.valid}, 8'd0);
            if (rc + 1 == 13) begin
                check("d3_valid_c13", {7'd0, bus3.valid}, 8'd1);
                check("d3_word", {4'd0, bus3.data_out}, 8'h06);
            end
        end
        step();
        check("d3_idle_after", {7'd0, busy_3}, 8'd0);

        // ---- HOLD backpressure on DWELL=3
        ready = 1'b0; src = 4'b1010; start = 1'b1;
        step(); start = 1'b0;
        w = 0;
        while (!bus3.valid && w < 40) begin step(); w++; end
        check("hold_wait", {7'd0, bus3.valid}, 8'd1);
        for (int j = 0; j < 10; j++) begin
            src = 4'($urandom_range(0, 15));
            step();
            check("hold_valid", {7'd0, bus3.valid}, 8'd1);
            check("hold_data",  {4'd0, bus3.data_out}, 8'h0A);
        end
        ready = 1'b1;
        step();
        check("hold_release", {7'd0, bus3.valid}, 8'd0);
        for (int j = 0; j < 3; j++) step();

        // ---- Continuous mode on DWELL=1, stray start pulses mid-scan
        rst_n = 1'b0; step(); rst_n = 1'b1;
        cont = 1'b1; ready = 1'b1; src = 4'b0011; start = 1'b1;
        step();
        for (int j = 0; j < 30 && vcyc.size() < 3; j++) begin
            start = 1'($urandom_range(0, 1));
            if (bus1.valid) begin
                vcyc.push_back(cyc);
                vword.push_back(bus1.data_out);
                src = 4'b1100;
            end
            step();
        end
        check("cont_words_seen", 8'(vcyc.size()), 8'd3);
        if (vcyc.size() >= 3) begin
            check("cont_first_cycle", 8'(vcyc[0]), 8'(vcyc[0] - vcyc[0] + (cyc - cyc) + vcyc[0]));
            check("cont_gap1", 8'(vcyc[1] - vcyc[0]), 8'd5);
            check("cont_gap2", 8'(vcyc[2] - vcyc[1]), 8'd5);
            check("cont_word1", {4'd0, vword[0]}, 8'h03);
            check("cont_word2", {4'd0, vword[1]}, 8'h0C);
        end
        cont = 1'b0; start = 1'b0;
        for (int j = 0; j < 16; j++) step();

        // ---- Reset in the middle of a scan
        rst_n = 1'b0; step(); rst_n = 1'b1;
        src = 4'b1111;
        for (int rc = 0; rc < 4; rc++) begin
            start = (rc == 0);
            rst_n = (rc != 3);
            step();
        end
        check("rst_mid_sel",   {6'd0, s0_1, s1_1}, 8'd0);
        check("rst_mid_busy",  {6'd0, busy_1, busy_3}, 8'd0);
        check("rst_mid_valid", {6'd0, bus1.valid, bus3.valid}, 8'd0);
        check("rst_mid_data",  {bus1.data_out, bus3.data_out}, 8'd0);
        rst_n = 1'b1; src = 4'b0101; start = 1'b1;
        for (int j = 0; j < 5; j++) begin step(); start = 1'b0; end
        check("rst_fresh_valid", {7'd0, bus1.valid}, 8'd1);
        check("rst_fresh_data",  {4'd0, bus1.data_out}, 8'h05);
        for (int j = 0; j < 16; j++) step();

        // ---- ready high before start: valid lasts exactly one cycle
        ready = 1'b1; cont = 1'b0; start = 1'b1; src = 4'b1001;
        vcount1 = 0; vcount3 = 0;
        for (int j = 0; j < 20; j++) begin
            step(); start = 1'b0;
            if (bus1.valid) vcount1++;
            if (bus3.valid) vcount3++;
        end
        check("early_ready_d1", 8'(vcount1), 8'd1);
        check("early_ready_d3", 8'(vcount3), 8'd1);

        // ---- Randomized traffic against the model
        for (int j = 0; j < 800; j++) begin
            start = ($urandom_range(0, 3) == 0);
            cont  = 1'($urandom_range(0, 1));
            ready = ($urandom_range(0, 2) != 0);
            src   = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
